hsync_receiver_module: RTL and testbench



---
 rtl/hsync_receiver_module.sv | 273 +++++++++++++++++++++++++++
 tb/tb_hsync_receiver_module.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/hsync_receiver_module.sv
// -----------------------------------------------------------------------------
// hsync_receiver_module
//
// Purpose:
//   Receive side of the VGA horizontal timing path. Recovers line timing from
//   an incoming active-low hsync, sampled on the pixel enable. It regenerates
//   display_time and a 7-bit hpixel address (one address per PIX_DIV pixels).
//   It checks sync pulse width and line length against nominal 640x480@60
//   timing and reports lock.
//
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous, active-high reset
//   pixel_clk     in   one-clk-wide pixel enable
//   hsync_in      in   incoming hsync, active low, asynchronous to clk
//   display_time  out  high while the FSM is in the active display window
//   hpixel[6:0]   out  horizontal pixel address, 0..127
//   locked        out  set after LOCK_LINES consecutive good lines
//   line_err      out  one-clk pulse on any timing violation
//   pulse_width   out  last measured sync pulse width, in pixel enables
//   err_count     out  (only with HSYNC_RX_ERR_COUNT_EN) saturating count of
//                      line_err pulses
//
// Optional feature macro: HSYNC_RX_ERR_COUNT_EN
//
// Counter convention:
//   cnt_reg is cleared on the enable that sees a falling edge and then counts
//   enables. On a later enable, cnt_reg + 1 is the number of enables since
//   that falling edge. This value is used for pulse width and line length.
//   Timeouts fire on the enable where the counter steps onto the limit.
// -----------------------------------------------------------------------------
module hsync_receiver_module #(
    parameter int H_PULSE    = 96,
    parameter int H_BACK     = 48,
    parameter int H_DISP     = 640,
    parameter int H_FRONT    = 16,
    parameter int PIX_DIV    = 5,
    parameter int TOL        = 2,
    parameter int LOCK_LINES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pixel_clk,
    input  logic       hsync_in,
    output logic       display_time,
    output logic [6:0] hpixel,
    output logic       locked,
    output logic       line_err,
    output logic [9:0] pulse_width
`ifdef HSYNC_RX_ERR_COUNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam int H_TOTAL = H_PULSE + H_BACK + H_DISP + H_FRONT;

    localparam logic [9:0] PW_MIN    = 10'(H_PULSE - TOL);
    localparam logic [9:0] PW_MAX    = 10'(H_PULSE + TOL);
    // Last counter value before the pulse timeout limit (H_PULSE+TOL+1).
    localparam logic [9:0] PULSE_TMO = 10'(H_PULSE + TOL);
    localparam logic [9:0] BACK_END  = 10'(H_PULSE + H_BACK - 1);
    localparam logic [9:0] DISP_END  = 10'(H_PULSE + H_BACK + H_DISP - 1);
    localparam logic [9:0] LINE_MIN  = 10'(H_TOTAL - TOL);
    localparam logic [9:0] LINE_MAX  = 10'(H_TOTAL + TOL);
    // Last counter value before the front porch timeout (H_TOTAL+TOL+1).
    localparam logic [9:0] FRONT_TMO = 10'(H_TOTAL + TOL);
    localparam logic [9:0] CNT_MAX   = 10'd1023;
    localparam logic [2:0] DIV_LAST  = 3'(PIX_DIV - 1);

    localparam int GW = $clog2(LOCK_LINES + 1);
    localparam logic [GW-1:0] GOOD_FULL = GW'(LOCK_LINES);

    typedef enum logic [2:0] {
        SEARCH = 3'd0,
        PULSE  = 3'd1,
        BACK   = 3'd2,
        DISP   = 3'd3,
        FRONT  = 3'd4
    } state_t;

    state_t state_reg, state_next;

    logic [1:0]    sync_reg;
    logic          samp_reg;
    logic [9:0]    cnt_reg;
    logic [9:0]    cnt_plus1;
    logic [9:0]    pulse_width_reg;
    logic [GW-1:0] good_reg, good_next;
    logic          locked_reg;
    logic          line_err_reg;
    logic [2:0]    div_reg;
    logic [6:0]    hpixel_reg;

    logic fall, rise;
    logic err_now;
    logic good_inc, good_clr;
    logic pw_load;
    logic in_disp_next;

    // Edges compare the current synchronized level against the level held from
    // the previous enable, so edges exist only on enable cycles.
    assign fall      = pixel_clk &  samp_reg & ~sync_reg[1];
    assign rise      = pixel_clk & ~samp_reg &  sync_reg[1];
    assign cnt_plus1 = cnt_reg + 10'd1;

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= SEARCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------ next state
    always_comb begin
        state_next = state_reg;
        err_now    = 1'b0;
        good_inc   = 1'b0;
        good_clr   = 1'b0;
        pw_load    = 1'b0;
        if (pixel_clk) begin
            case (state_reg)
                SEARCH: begin
                    if (fall) begin
                        state_next = PULSE;
                    end
                end
                PULSE: begin
                    if (rise) begin
                        pw_load = 1'b1;
                        if ((cnt_plus1 >= PW_MIN) && (cnt_plus1 <= PW_MAX)) begin
                            state_next = BACK;
                        end else begin
                            err_now    = 1'b1;
                            good_clr   = 1'b1;
                            state_next = SEARCH;
                        end
                    end else if (cnt_reg >= PULSE_TMO) begin
                        err_now    = 1'b1;
                        good_clr   = 1'b1;
                        state_next = SEARCH;
                    end
                end
                BACK: begin
                    // A falling edge here means the line was too short. Restart
                    // the pulse measurement on this edge.
                    if (fall) begin
                        err_now    = 1'b1;
                        good_clr   = 1'b1;
                        state_next = PULSE;
                    end else if (cnt_reg == BACK_END) begin
                        state_next = DISP;
                    end
                end
                DISP: begin
                    if (fall) begin
                        err_now    = 1'b1;
                        good_clr   = 1'b1;
                        state_next = PULSE;
                    end else if (cnt_reg == DISP_END) begin
                        state_next = FRONT;
                    end
                end
                FRONT: begin
                    if (fall) begin
                        state_next = PULSE;
                        if ((cnt_plus1 >= LINE_MIN) && (cnt_plus1 <= LINE_MAX)) begin
                            good_inc = 1'b1;
                        end else begin
                            err_now  = 1'b1;
                            good_clr = 1'b1;
                        end
                    end else if (cnt_reg >= FRONT_TMO) begin
                        err_now    = 1'b1;
                        good_clr   = 1'b1;
                        state_next = SEARCH;
                    end
                end
                default: begin
                    state_next = SEARCH;
                end
            endcase
        end
    end

    // --------------------------------------------------------------- outputs
    always_comb begin
        display_time = (state_reg == DISP);
    end

    assign in_disp_next = (state_reg == DISP) && (state_next == DISP);

    always_comb begin
        good_next = good_reg;
        if (good_clr) begin
            good_next = '0;
        end else if (good_inc && (good_reg != GOOD_FULL)) begin
            good_next = good_reg + 1'b1;
        end
    end

    // -------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg        <= 2'b11;
            samp_reg        <= 1'b1;
            cnt_reg         <= '0;
            pulse_width_reg <= '0;
            good_reg        <= '0;
            locked_reg      <= 1'b0;
            line_err_reg    <= 1'b0;
            div_reg         <= '0;
            hpixel_reg      <= '0;
        end else begin
            sync_reg     <= {sync_reg[0], hsync_in};
            line_err_reg <= err_now;
            if (pixel_clk) begin
                samp_reg <= sync_reg[1];

                if (fall) begin
                    cnt_reg <= '0;
                end else if (cnt_reg != CNT_MAX) begin
                    cnt_reg <= cnt_plus1;
                end

                if (pw_load) begin
                    pulse_width_reg <= cnt_plus1;
                end

                // Lock follows the good-line count. An error clears the count,
                // so lock drops on the same edge that raises line_err.
                good_reg   <= good_next;
                locked_reg <= (good_next == GOOD_FULL);

                // Divider and address run only while staying in DISP. Any exit
                // from DISP, including a short-line falling edge, zeroes both.
                if (in_disp_next) begin
                    if (div_reg == DIV_LAST) begin
                        div_reg    <= '0;
                        hpixel_reg <= hpixel_reg + 7'd1;
                    end else begin
                        div_reg <= div_reg + 3'd1;
                    end
                end else begin
                    div_reg    <= '0;
                    hpixel_reg <= '0;
                end
            end
        end
    end

    assign hpixel      = hpixel_reg;
    assign locked      = locked_reg;
    assign line_err    = line_err_reg;
    assign pulse_width = pulse_width_reg;

`ifdef HSYNC_RX_ERR_COUNT_EN
    logic [7:0] err_cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt_reg <= '0;
        end else if (err_now && (err_cnt_reg != 8'hFF)) begin
            err_cnt_reg <= err_cnt_reg + 8'd1;
        end
    end

    assign err_count = err_cnt_reg;
`endif

endmodule

// File: tb/tb_hsync_receiver_module.sv
module tb_hsync_receiver_module;

    logic       clk = 1'b0;
    logic       reset;
    logic       pixel_clk;
    logic       hsync_in;
    logic       display_time;
    logic [6:0] hpixel;
    logic       locked;
    logic       line_err;
    logic [9:0] pulse_width;
`ifdef HSYNC_RX_ERR_COUNT_EN
    logic [7:0] err_count;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int stray_err = 0;

    typedef struct {
        int   low;          // enables with hsync low at line start
        int   high;         // enables with hsync high after that
        int   exp_err;      // line_err pulses seen during this line
        int   exp_err_step; // step index of first line_err, -1 if none
        int   exp_pw;       // pulse_width at end of line
        logic exp_lock;     // locked at end of line
        int   exp_disp;     // enables with display_time high
    } vec_t;

    vec_t tab_a[5];
    vec_t tab_b[11];

    hsync_receiver_module dut (
        .clk          (clk),
        .reset        (reset),
        .pixel_clk    (pixel_clk),
        .hsync_in     (hsync_in),
        .display_time (display_time),
        .hpixel       (hpixel),
        .locked       (locked),
        .line_err     (line_err),
        .pulse_width  (pulse_width)
`ifdef HSYNC_RX_ERR_COUNT_EN
        ,
        .err_count    (err_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One pixel enable: hold hsync for three clocks so the synchronizer
    // settles, then pulse pixel_clk for one clk. The task returns at the
    // negedge after the enable edge.
    task automatic step(input logic hs);
        hsync_in  = hs;
        pixel_clk = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (line_err) stray_err++;
        end
        pixel_clk = 1'b1;
        @(negedge clk);
        pixel_clk = 1'b0;
    endtask

    task automatic run_line(input int low, input int high,
                            output int n_err, output int first_err,
                            output int disp_n, output int first_disp,
                            output int hpx_bad);
        n_err = 0; first_err = -1; disp_n = 0; first_disp = -1; hpx_bad = 0;
        for (int k = 0; k < low + high; k++) begin
            step((k < low) ? 1'b0 : 1'b1);
            if (line_err) begin
                n_err++;
                if (first_err < 0) first_err = k;
            end
            if (display_time) begin
                disp_n++;
                if (first_disp < 0) first_disp = k;
                if (k < 144 || int'(hpixel) != (k - 144) / 5) hpx_bad++;
            end else if (hpixel != 7'd0) begin
                hpx_bad++;
            end
        end
    endtask

    task automatic run_rec(input vec_t v, input string tag);
        int n_err, first_err, disp_n, first_disp, hpx_bad;
        stray_err = 0;
        run_line(v.low, v.high, n_err, first_err, disp_n, first_disp, hpx_bad);
        $display("%s: low %0d high %0d line_err %0d@%0d pw %0d locked %0b disp %0d",
                 tag, v.low, v.high, n_err, first_err, pulse_width, locked, disp_n);
        check({tag, " err_count"}, n_err, v.exp_err);
        check({tag, " err_step"}, first_err, v.exp_err_step);
        check({tag, " pulse_width"}, int'(pulse_width), v.exp_pw);
        check({tag, " locked"}, int'(locked), int'(v.exp_lock));
        check({tag, " disp_len"}, disp_n, v.exp_disp);
        check({tag, " hpixel"}, hpx_bad, 0);
        check({tag, " err_single_clk"}, stray_err, 0);
        if (v.exp_disp > 0) check({tag, " disp_start"}, first_disp, 144);
    endtask

    initial begin
        int n_err, first_err, disp_n, first_disp, hpx_bad;

        for (int i = 0; i < 5; i++)
            tab_a[i] = '{96, 704, 0, -1, 96, (i == 4), 640};
        tab_b[0]  = '{90,  20, 1,  90, 90, 1'b0,   0}; // short pulse after lock
        tab_b[1]  = '{96, 704, 0,  -1, 96, 1'b0, 640}; // from SEARCH
        tab_b[2]  = '{96, 702, 0,  -1, 96, 1'b0, 640}; // 798 line
        tab_b[3]  = '{96, 706, 0,  -1, 96, 1'b0, 640}; // 802 line, 798 accepted
        tab_b[4]  = '{96, 704, 0,  -1, 96, 1'b0, 640}; // 802 accepted
        tab_b[5]  = '{96, 701, 0,  -1, 96, 1'b1, 640}; // 797 line, relock here
        tab_b[6]  = '{96, 704, 1,   0, 96, 1'b0, 640}; // 797 rejected
        tab_b[7]  = '{96, 724, 1, 803, 96, 1'b0, 640}; // 820 line, front timeout
        tab_b[8]  = '{96, 704, 0,  -1, 96, 1'b0, 640}; // from SEARCH
        tab_b[9]  = '{96, 305, 0,  -1, 96, 1'b0, 257}; // cut at counter 400
        tab_b[10] = '{96, 704, 1,   0, 96, 1'b0, 640}; // short-line edge in DISP

        reset = 1'b1; pixel_clk = 1'b0; hsync_in = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset display_time", int'(display_time), 0);
        check("reset hpixel", int'(hpixel), 0);
        check("reset locked", int'(locked), 0);
        check("reset line_err", int'(line_err), 0);
        check("reset pulse_width", int'(pulse_width), 0);

        for (int i = 0; i < 5; i++) run_rec(tab_a[i], $sformatf("nominal%0d", i));

        // Locked line cut by reset at counter 500.
        stray_err = 0;
        run_line(96, 405, n_err, first_err, disp_n, first_disp, hpx_bad);
        $display("prereset: line_err %0d locked %0b disp %0b", n_err, locked, display_time);
        check("prereset err", n_err, 0);
        check("prereset locked", int'(locked), 1);
        check("prereset display", int'(display_time), 1);
        check("prereset hpixel", int'(hpixel), 71);
        #2 reset = 1'b1;
        #1;
        $display("reset asserted: disp %0b hpixel %0d locked %0b pw %0d",
                 display_time, hpixel, locked, pulse_width);
        check("async reset display_time", int'(display_time), 0);
        check("async reset hpixel", int'(hpixel), 0);
        check("async reset locked", int'(locked), 0);
        check("async reset line_err", int'(line_err), 0);
        check("async reset pulse_width", int'(pulse_width), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) run_rec(tab_a[i], $sformatf("relock%0d", i));
        for (int i = 0; i < 11; i++) run_rec(tab_b[i], $sformatf("corner%0d", i));

`ifdef HSYNC_RX_ERR_COUNT_EN
        check("err_count tally", int'(err_count), 4);
        for (int i = 0; i < 300; i++) begin
            run_line(2, 2, n_err, first_err, disp_n, first_disp, hpx_bad);
        end
        $display("bad pulses: err_count %0d", err_count);
        check("err_count saturate", int'(err_count), 255);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
